// File: rtl/word_pkg.sv
// Shared constants and FSM state type for the word typing checker.
package word_pkg;

  localparam int unsigned LETTERS = 4;
  localparam int unsigned CHAR_W  = 5;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned WORD_W  = LETTERS * CHAR_W;

  localparam logic [CHAR_W-1:0] BKSP_CODE = CHAR_W'(31);
  localparam logic [CHAR_W-1:0] LETTER_A  = CHAR_W'(1);
  localparam logic [CHAR_W-1:0] LETTER_Z  = CHAR_W'(26);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TYPING,
    DONE,
    SYNC
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_inc && (r_q != {CNT_W{1'b1}})) begin
      r_q <= r_q + CNT_W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/word_typing_checker.sv
// Checks keystrokes against a snapshotted word and pulses wordComplete when typed exactly.
module word_typing_checker
  import word_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               key_valid,
  input  logic [CHAR_W-1:0]  key_code,
  input  logic [WORD_W-1:0]  currentWord,
  output logic               wordComplete,
  output logic [IDX_W-1:0]   char_index,
  output logic [LETTERS-1:0] typed_mask,
  output logic [LETTERS-1:0] error_mask,
  output logic               word_error,
  output logic [CNT_W-1:0]   correct_cnt,
  output logic [CNT_W-1:0]   error_cnt,
  output logic [CNT_W-1:0]   words_done,
  output logic               busy
);

  // Letter 0 sits in the most significant slot.
  function automatic logic [CHAR_W-1:0] letter_at(input logic [WORD_W-1:0] w,
                                                   input logic [IDX_W-1:0]  idx);
    logic [CHAR_W-1:0] l;
    l = '0;
    for (int unsigned i = 0; i < LETTERS; i++) begin
      if (idx == IDX_W'(i)) l = w[WORD_W-1-i*CHAR_W -: CHAR_W];
    end
    return l;
  endfunction

  function automatic logic [IDX_W-1:0] word_len(input logic [WORD_W-1:0] w);
    logic [IDX_W-1:0] n;
    logic             run;
    n   = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < LETTERS; i++) begin
      if (run && (w[WORD_W-1-i*CHAR_W -: CHAR_W] != '0)) n = n + IDX_W'(1);
      else run = 1'b0;
    end
    return n;
  endfunction

  state_e             r_state, w_state_next;
  logic [WORD_W-1:0]  r_word;
  logic [IDX_W-1:0]   r_len, r_idx;
  logic [LETTERS-1:0] r_typed, r_err;
  logic               r_complete;

  logic               w_is_letter, w_is_bksp, w_done_cond, w_key_act;
  logic               w_type_ok, w_bksp_ok, w_match;
  logic [LETTERS-1:0] w_pos_oh, w_prev_oh;

  assign w_is_letter = (key_code >= LETTER_A) && (key_code <= LETTER_Z);
  assign w_is_bksp   = (key_code == BKSP_CODE);
  assign w_done_cond = (r_idx == r_len) && (r_err == '0);
  // Completion takes priority: a key arriving in the completing cycle is dropped.
  assign w_key_act   = start && key_valid && (r_state == TYPING) && !w_done_cond;
  assign w_type_ok   = w_key_act && w_is_letter && (r_idx < r_len);
  assign w_bksp_ok   = w_key_act && w_is_bksp && (r_idx != '0);
  assign w_match     = (key_code == letter_at(r_word, r_idx));
  assign w_pos_oh    = LETTERS'(1) << r_idx;
  assign w_prev_oh   = LETTERS'(1) << (r_idx - IDX_W'(1));

  always_comb begin
    w_state_next = r_state;
    if (!start) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = LOAD;
        LOAD:    w_state_next = TYPING;
        TYPING:  if (w_done_cond) w_state_next = DONE;
        DONE:    w_state_next = SYNC;
        SYNC:    w_state_next = LOAD;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_complete <= 1'b0;
      r_word     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_typed    <= '0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_complete <= (w_state_next == DONE);
      if (!start) begin
        r_idx   <= '0;
        r_typed <= '0;
        r_err   <= '0;
      end else if (r_state == LOAD) begin
        r_word  <= currentWord;
        r_len   <= word_len(currentWord);
        r_idx   <= '0;
        r_typed <= '0;
        r_err   <= '0;
      end else if (w_type_ok) begin
        r_typed <= r_typed | w_pos_oh;
        r_err   <= w_match ? r_err : (r_err | w_pos_oh);
        r_idx   <= r_idx + IDX_W'(1);
      end else if (w_bksp_ok) begin
        r_typed <= r_typed & ~w_prev_oh;
        r_err   <= r_err & ~w_prev_oh;
        r_idx   <= r_idx - IDX_W'(1);
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_correct_cnt (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_inc   (w_type_ok && w_match),
    .o_q     (correct_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_error_cnt (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_inc   (w_type_ok && !w_match),
    .o_q     (error_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_words_done (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_inc   (r_state == DONE),
    .o_q     (words_done)
  );

  assign wordComplete = r_complete;
  assign char_index   = r_idx;
  assign typed_mask   = r_typed;
  assign error_mask   = r_err;
  assign word_error   = |r_err;
  assign busy         = (r_state == TYPING);

endmodule

// File: tb/tb_word_typing_checker.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// stimulus, all compared every cycle against a queue-based behavioural model.
module tb_word_typing_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start, key_valid;
  logic [4:0]  key_code;
  logic [19:0] currentWord;
  logic        wordComplete, word_error, busy;
  logic [2:0]  char_index;
  logic [3:0]  typed_mask, error_mask;
  logic [7:0]  correct_cnt, error_cnt, words_done;

  int checks = 0;
  int failures = 0;
  int print_cnt = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  word_typing_checker dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .currentWord  (currentWord),
    .wordComplete (wordComplete),
    .char_index   (char_index),
    .typed_mask   (typed_mask),
    .error_mask   (error_mask),
    .word_error   (word_error),
    .correct_cnt  (correct_cnt),
    .error_cnt    (error_cnt),
    .words_done   (words_done),
    .busy         (busy)
  );

  // Model: phase 0 idle, 1 load, 2 typing, 3 done, 4 sync; typed letters kept as a queue.
  int m_phase;
  int m_word[4];
  int m_len;
  int m_typed[$];
  int m_correct, m_error, m_words;

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  function automatic logic [3:0] exp_typed();
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < m_typed.size(); i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] exp_err();
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < m_typed.size(); i++) if (m_typed[i] != m_word[i]) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    foreach (m_word[i]) m_word[i] = 0;
    m_len = 0;
    m_typed.delete();
    m_correct = 0;
    m_error = 0;
    m_words = 0;
  endtask

  task automatic model_step();
    int  ph;
    int  k;
    bit  done_c;
    bit  run;
    ph = m_phase;
    done_c = (m_typed.size() == m_len) && (exp_err() == 4'b0);
    if (ph == 3) m_words = sat_inc(m_words);
    if (!start) begin
      m_phase = 0;
      m_typed.delete();
    end else begin
      case (ph)
        0: m_phase = 1;
        1: begin
          m_len = 0;
          run = 1'b1;
          for (int i = 0; i < 4; i++) begin
            m_word[i] = int'(currentWord[19-5*i -: 5]);
            if (run && m_word[i] != 0) m_len++;
            else run = 1'b0;
          end
          m_typed.delete();
          m_phase = 2;
        end
        2: begin
          if (done_c) begin
            m_phase = 3;
          end else if (key_valid) begin
            k = int'(key_code);
            if (k >= 1 && k <= 26) begin
              if (m_typed.size() < m_len) begin
                if (k == m_word[m_typed.size()]) m_correct = sat_inc(m_correct);
                else m_error = sat_inc(m_error);
                m_typed.push_back(k);
              end
            end else if (k == 31 && m_typed.size() > 0) begin
              void'(m_typed.pop_back());
            end
          end
        end
        3: m_phase = 4;
        4: m_phase = 1;
        default: m_phase = 0;
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (print_cnt < 40) begin
        print_cnt++;
        $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_wordComplete", 32'(wordComplete), 32'(m_phase == 3));
        chk("m_busy",         32'(busy),         32'(m_phase == 2));
        chk("m_char_index",   32'(char_index),   32'(m_typed.size()));
        chk("m_typed_mask",   32'(typed_mask),   32'(exp_typed()));
        chk("m_error_mask",   32'(error_mask),   32'(exp_err()));
        chk("m_word_error",   32'(word_error),   32'(|exp_err()));
        chk("m_correct_cnt",  32'(correct_cnt),  32'(m_correct));
        chk("m_error_cnt",    32'(error_cnt),    32'(m_error));
        chk("m_words_done",   32'(words_done),   32'(m_words));
      end
    end
  end

  function automatic logic [19:0] mk_word(input int a, input int b, input int c, input int d);
    return {5'(a), 5'(b), 5'(c), 5'(d)};
  endfunction

  function automatic logic [19:0] rand_word();
    int n;
    logic [19:0] w;
    n = $urandom_range(0, 4);
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < n || $urandom_range(0, 3) == 0) w[19-5*i -: 5] = 5'($urandom_range(1, 26));
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int k);
    key_valid = 1'b1;
    key_code  = 5'(k);
    tick();
    key_valid = 1'b0;
    key_code  = '0;
  endtask

  task automatic wait_wc(input int max_edges);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max_edges; i++) begin
      tick();
      if (wordComplete) begin
        got = 1'b1;
        break;
      end
    end
    chk("wc_within_bound", 32'(got), 32'd1);
  endtask

  int sel;
  int pos;

  initial begin
    start       = 1'b0;
    key_valid   = 1'b0;
    key_code    = '0;
    currentWord = '0;
    repeat (2) tick();
    cmp_en = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(char_index), 0);
    chk("rst_words", 32'(words_done), 0);
    chk("rst_wc", 32'(wordComplete), 0);

    // CATS typed cleanly
    currentWord = mk_word(3, 1, 20, 19);
    start = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    chk("cats_busy", 32'(busy), 1);
    press(3); press(1); press(20); press(19);
    chk("cats_idx", 32'(char_index), 4);
    chk("cats_wc_early", 32'(wordComplete), 0);
    tick();
    chk("cats_wc_2edges", 32'(wordComplete), 1);
    tick();
    chk("cats_wc_drop", 32'(wordComplete), 0);
    chk("cats_words", 32'(words_done), 1);
    chk("cats_correct", 32'(correct_cnt), 4);
    chk("cats_errmask", 32'(error_mask), 0);
    tick(); tick();
    chk("cats_typing_3edges", 32'(busy), 1);

    // CATS with a typo and backspace
    press(3); press(2);
    chk("typo_errmask", 32'(error_mask), 32'h2);
    chk("typo_word_error", 32'(word_error), 1);
    chk("typo_error_cnt", 32'(error_cnt), 1);
    press(31);
    chk("bksp_idx", 32'(char_index), 1);
    chk("bksp_typed", 32'(typed_mask), 32'h1);
    press(1); press(20);
    currentWord = mk_word(4, 15, 7, 0);
    press(19);
    chk("fix_errmask", 32'(error_mask), 0);
    tick();
    chk("fix_wc", 32'(wordComplete), 1);
    chk("fix_correct", 32'(correct_cnt), 8);

    // DOG with pad; keys during DONE/SYNC dropped
    tick(); tick(); tick();
    press(4); press(15); press(7);
    chk("dog_idx", 32'(char_index), 3);
    tick();
    chk("dog_wc", 32'(wordComplete), 1);
    press(5);
    currentWord = '0;
    press(5);
    chk("dog_correct", 32'(correct_cnt), 11);
    chk("dog_error", 32'(error_cnt), 1);
    chk("dog_words", 32'(words_done), 3);

    // Empty word completes without keys
    tick();
    chk("empty_idx", 32'(char_index), 0);
    tick();
    chk("empty_wc", 32'(wordComplete), 1);
    currentWord = mk_word(3, 1, 20, 19);
    tick(); tick(); tick();
    chk("empty_words", 32'(words_done), 4);
    press(31);
    chk("bksp0_idx", 32'(char_index), 0);

    // Full word with one error, extra key ignored, then saturation
    press(3); press(1); press(20); press(5);
    chk("err4_mask", 32'(error_mask), 32'h8);
    press(7);
    chk("extra_idx", 32'(char_index), 4);
    chk("extra_error", 32'(error_cnt), 2);
    chk("extra_correct", 32'(correct_cnt), 14);
    tick();
    chk("extra_no_wc", 32'(wordComplete), 0);
    press(31); press(19);
    wait_wc(4);
    for (int w = 0; w < 64; w++) begin
      tick(); tick(); tick();
      press(3); press(1); press(20); press(19);
      wait_wc(4);
    end
    tick();
    chk("sat_correct", 32'(correct_cnt), 255);
    chk("sat_words", 32'(words_done), 69);

    // start dropped mid-word
    tick(); tick();
    press(3); press(1);
    start = 1'b0;
    tick();
    chk("stop_busy", 32'(busy), 0);
    chk("stop_idx", 32'(char_index), 0);
    chk("stop_correct", 32'(correct_cnt), 255);
    start = 1'b1;
    tick(); tick();

    // Asynchronous reset mid-word
    press(3); press(9);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_idx", 32'(char_index), 0);
    chk("arst_err", 32'(error_mask), 0);
    chk("arst_correct", 32'(correct_cnt), 0);
    chk("arst_words", 32'(words_done), 0);
    chk("arst_busy", 32'(busy), 0);
    currentWord = mk_word(4, 15, 7, 0);
    tick();
    reset = 1'b1;
    tick(); tick();
    press(4); press(15); press(7);
    tick();
    chk("arst_reload_wc", 32'(wordComplete), 1);
    chk("arst_reload_correct", 32'(correct_cnt), 3);

    // Randomized stimulus, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      key_valid = 1'b0;
      key_code  = '0;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) reset = 1'b0;
      start = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 24) == 0) currentWord = rand_word();
      if ($urandom_range(0, 1) == 1) begin
        key_valid = 1'b1;
        sel = $urandom_range(0, 99);
        pos = m_typed.size();
        if (sel < 60 && pos < 4 && m_word[pos] != 0) key_code = 5'(m_word[pos]);
        else if (sel < 75) key_code = 5'd31;
        else key_code = 5'($urandom_range(0, 31));
      end
      tick();
    end
    key_valid = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
